// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the three buses around the load/store controller:
//   - execute-side request handshake (in_*)
//   - memory port: ea/result/mem_en out, asynchronous read data in
//   - writeback-side response handshake (wb_*)
//   Optional MEM_ACCESS_POSTINC_EN adds wb_base / wb_base_we.
//   Modports: slave = controller view, master = surrounding pipeline/memory.
interface mem_access_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int TW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_base;
    logic [AW-1:0] in_off;
    logic [DW-1:0] in_wdata;
    logic [TW-1:0] in_rd;
    logic [AW-1:0] ea;
    logic [DW-1:0] result;
    logic          mem_en;
    logic [DW-1:0] data;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [TW-1:0] wb_rd;
`ifdef MEM_ACCESS_POSTINC_EN
    logic [AW-1:0] wb_base;
    logic          wb_base_we;
`endif

    modport slave (
        input  in_valid, in_op, in_base, in_off, in_wdata, in_rd, data, wb_ready,
        output in_ready, ea, result, mem_en, wb_valid, wb_data, wb_rd
`ifdef MEM_ACCESS_POSTINC_EN
        , output wb_base, wb_base_we
`endif
    );

    modport master (
        output in_valid, in_op, in_base, in_off, in_wdata, in_rd, data, wb_ready,
        input  in_ready, ea, result, mem_en, wb_valid, wb_data, wb_rd
`ifdef MEM_ACCESS_POSTINC_EN
        , input wb_base, wb_base_we
`endif
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Load/store/swap controller in front of a 256x8 data memory.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - mem_access_ctrl_if.slave (request, memory port, writeback)
//   Optional feature macro: MEM_ACCESS_POSTINC_EN (wb_base / wb_base_we
//   post-increment base writeback).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | in_ready=1, waiting for an operation
//   RD    | memory read data sampled into wb_data at the next edge
//   WR    | mem_en=1 for one cycle; memory commits on the falling edge
//   WB    | wb_valid=1, waiting for wb_ready
module mem_access_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int TW = 3
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    op_q;
    logic [TW-1:0] tag_q;
    logic [AW-1:0] ea_next;

    // Same-width addition of the raw offset equals base + sign_extend(off)
    // modulo 2^AW, so negative offsets wrap correctly without extension.
    assign ea_next = bus.in_base + bus.in_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            op_q         <= OP_NOP;
            tag_q        <= '0;
            bus.in_ready <= 1'b1;
            bus.mem_en   <= 1'b0;
            bus.ea       <= '0;
            bus.result   <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_data  <= '0;
            bus.wb_rd    <= '0;
`ifdef MEM_ACCESS_POSTINC_EN
            bus.wb_base    <= '0;
            bus.wb_base_we <= 1'b0;
`endif
        end else begin
`ifdef MEM_ACCESS_POSTINC_EN
            bus.wb_base_we <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // NOP is consumed without touching ea/result or leaving IDLE.
                    if (bus.in_valid && bus.in_op != OP_NOP) begin
                        bus.ea       <= ea_next;
                        bus.result   <= bus.in_wdata;
                        tag_q        <= bus.in_rd;
                        op_q         <= bus.in_op;
                        bus.in_ready <= 1'b0;
                        if (bus.in_op == OP_STORE) begin
                            state      <= S_WR;
                            bus.mem_en <= 1'b1;
`ifdef MEM_ACCESS_POSTINC_EN
                            // A store completes in its WR cycle.
                            bus.wb_base    <= ea_next + AW'(1);
                            bus.wb_base_we <= 1'b1;
`endif
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    bus.wb_data <= bus.data;
                    if (op_q == OP_SWAP) begin
                        // Straight to WR so nothing can slip between read and write.
                        state      <= S_WR;
                        bus.mem_en <= 1'b1;
                    end else begin
                        state        <= S_WB;
                        bus.wb_valid <= 1'b1;
                        bus.wb_rd    <= tag_q;
                    end
                end
                S_WR: begin
                    bus.mem_en <= 1'b0;
                    if (op_q == OP_SWAP) begin
                        state        <= S_WB;
                        bus.wb_valid <= 1'b1;
                        bus.wb_rd    <= tag_q;
                    end else begin
                        state        <= S_IDLE;
                        bus.in_ready <= 1'b1;
                    end
                end
                S_WB: begin
                    if (bus.wb_ready) begin
                        state        <= S_IDLE;
                        bus.wb_valid <= 1'b0;
                        bus.in_ready <= 1'b1;
`ifdef MEM_ACCESS_POSTINC_EN
                        bus.wb_base    <= bus.ea + AW'(1);
                        bus.wb_base_we <= 1'b1;
`endif
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b1;
                    bus.mem_en   <= 1'b0;
                    bus.wb_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Bench for mem_access_ctrl: behavioural 256x8 memory, directed vector
//   table, reset-abort sequence and randomized operations checked against
//   an array-based reference of memory contents.
module tb_mem_access_ctrl;
    localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, STORE = 2'b10, SWAP = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clear = 1'b1;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.AW(8), .DW(8), .TW(3)) bus ();

    mem_access_ctrl #(.AW(8), .DW(8), .TW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory: asynchronous read, write committed on the falling edge.
    logic [7:0] mem [256];
    assign bus.data = mem[bus.ea];
    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (bus.mem_en) begin
            mem[bus.ea] <= bus.result;
        end
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    logic [7:0] last_ea;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] eff_addr(input logic [7:0] base, input logic [7:0] off);
        int s;
        s = (int'(off) >= 128) ? int'(off) - 256 : int'(off);
        return 8'((int'(base) + s + 256) % 256);
    endfunction

    // Issues one operation and checks its cycle-by-cycle behaviour.
    task automatic do_op(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                         input logic [7:0] wdata, input logic [2:0] rd, input int hold,
                         output logic [7:0] got_ea, output logic [7:0] got_wb);
        logic [7:0] a;
        logic [7:0] exp_d;
        int n;
        a      = eff_addr(base, off);
        exp_d  = 8'h00;
        got_wb = 8'h00;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_base  = base;
        bus.in_off   = off;
        bus.in_wdata = wdata;
        bus.in_rd    = rd;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            got_ea = bus.ea;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 2'($urandom);
        bus.in_base  = 8'($urandom);
        got_ea = bus.ea;

        if (op == NOP) begin
            check("nop_in_ready", 32'(bus.in_ready), 32'd1);
            check("nop_ea_hold", 32'(bus.ea), 32'(last_ea));
            check("nop_mem_en", 32'(bus.mem_en), 32'd0);
            check("nop_wb_valid", 32'(bus.wb_valid), 32'd0);
            return;
        end
        last_ea = a;
        check("ea", 32'(bus.ea), 32'(a));
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        check("wb_valid_t0", 32'(bus.wb_valid), 32'd0);

        if (op == STORE) begin
            check("store_mem_en_t0", 32'(bus.mem_en), 32'd1);
            check("store_result", 32'(bus.result), 32'(wdata));
`ifdef MEM_ACCESS_POSTINC_EN
            check("store_base_we", 32'(bus.wb_base_we), 32'd1);
            check("store_wb_base", 32'(bus.wb_base), 32'(8'(a + 8'd1)));
`endif
            ref_mem[a] = wdata;
            @(posedge clk); #1;
            check("store_mem_en_t1", 32'(bus.mem_en), 32'd0);
            check("store_in_ready_t1", 32'(bus.in_ready), 32'd1);
            check("store_no_wb", 32'(bus.wb_valid), 32'd0);
            check("store_mem_written", 32'(mem[a]), 32'(wdata));
`ifdef MEM_ACCESS_POSTINC_EN
            check("store_base_we_off", 32'(bus.wb_base_we), 32'd0);
`endif
            return;
        end

        check("rd_mem_en", 32'(bus.mem_en), 32'd0);
        exp_d = ref_mem[a];
        if (op == SWAP) begin
            @(posedge clk); #1;
            check("swap_mem_en_wr", 32'(bus.mem_en), 32'd1);
            check("swap_result", 32'(bus.result), 32'(wdata));
            check("swap_wb_valid_wr", 32'(bus.wb_valid), 32'd0);
            ref_mem[a] = wdata;
        end
        @(posedge clk); #1;
        check("wb_valid", 32'(bus.wb_valid), 32'd1);
        check("wb_data", 32'(bus.wb_data), 32'(exp_d));
        check("wb_rd", 32'(bus.wb_rd), 32'(rd));
        check("wb_mem_en", 32'(bus.mem_en), 32'd0);
        check("wb_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef MEM_ACCESS_POSTINC_EN
        check("wb_base_we_pre", 32'(bus.wb_base_we), 32'd0);
`endif
        got_wb = bus.wb_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_wb_valid", 32'(bus.wb_valid), 32'd1);
            check("hold_wb_data", 32'(bus.wb_data), 32'(exp_d));
            check("hold_wb_rd", 32'(bus.wb_rd), 32'(rd));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.wb_ready = 1'b1;
        @(posedge clk); #1;
        bus.wb_ready = 1'b0;
        check("hs_wb_valid_low", 32'(bus.wb_valid), 32'd0);
        check("hs_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef MEM_ACCESS_POSTINC_EN
        check("hs_base_we", 32'(bus.wb_base_we), 32'd1);
        check("hs_wb_base", 32'(bus.wb_base), 32'(8'(a + 8'd1)));
        @(posedge clk); #1;
        check("hs_base_we_off", 32'(bus.wb_base_we), 32'd0);
`endif
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] base;
        logic [7:0] off;
        logic [7:0] wdata;
        logic [2:0] rd;
        int         hold;
        logic [7:0] exp_ea;
        logic [7:0] exp_wb;
    } vec_t;

    vec_t vecs [11];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] g_ea, g_wb;
        logic [1:0] rop;
        vecs[0]  = '{STORE, 8'h10, 8'h05, 8'h7F, 3'd1, 0, 8'h15, 8'h00};
        vecs[1]  = '{LOAD,  8'h10, 8'h05, 8'h00, 3'd2, 0, 8'h15, 8'h7F};
        vecs[2]  = '{STORE, 8'h02, 8'hFD, 8'h11, 3'd3, 0, 8'hFF, 8'h00};
        vecs[3]  = '{LOAD,  8'hFF, 8'h01, 8'h00, 3'd4, 1, 8'h00, 8'h00};
        vecs[4]  = '{LOAD,  8'hF0, 8'h0F, 8'h00, 3'd5, 0, 8'hFF, 8'h11};
        vecs[5]  = '{STORE, 8'h40, 8'h00, 8'h33, 3'd0, 0, 8'h40, 8'h00};
        vecs[6]  = '{SWAP,  8'h40, 8'h00, 8'hA5, 3'd5, 0, 8'h40, 8'h33};
        vecs[7]  = '{LOAD,  8'h3F, 8'h01, 8'h00, 3'd6, 0, 8'h40, 8'hA5};
        vecs[8]  = '{LOAD,  8'h30, 8'h10, 8'h00, 3'd7, 5, 8'h40, 8'hA5};
        vecs[9]  = '{NOP,   8'h12, 8'h34, 8'h56, 3'd1, 0, 8'h40, 8'h00};
        vecs[10] = '{LOAD,  8'h50, 8'h80, 8'h00, 3'd2, 2, 8'hD0, 8'h00};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        last_ea      = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_op    = NOP;
        bus.in_base  = 8'h00;
        bus.in_off   = 8'h00;
        bus.in_wdata = 8'h00;
        bus.in_rd    = 3'd0;
        bus.wb_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_ea", 32'(bus.ea), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_data", 32'(bus.wb_data), 32'd0);
        check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
`ifdef MEM_ACCESS_POSTINC_EN
        check("rst_wb_base", 32'(bus.wb_base), 32'd0);
        check("rst_wb_base_we", 32'(bus.wb_base_we), 32'd0);
`endif
        mem_clear = 1'b0;
        rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].base, vecs[i].off, vecs[i].wdata, vecs[i].rd,
                  vecs[i].hold, g_ea, g_wb);
            check($sformatf("vec%0d_ea", i), 32'(g_ea), 32'(vecs[i].exp_ea));
            if (vecs[i].op == LOAD || vecs[i].op == SWAP)
                check($sformatf("vec%0d_wb", i), 32'(g_wb), 32'(vecs[i].exp_wb));
        end

        // Reset asserted during the WR cycle of a SWAP aborts it before the write.
        do_op(STORE, 8'h50, 8'h00, 8'h33, 3'd0, 0, g_ea, g_wb);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = SWAP;
        bus.in_base  = 8'h50;
        bus.in_off   = 8'h00;
        bus.in_wdata = 8'h99;
        bus.in_rd    = 3'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_en_wr", 32'(bus.mem_en), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_mem_en", 32'(bus.mem_en), 32'd0);
        check("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_ea", 32'(bus.ea), 32'd0);
        last_ea = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_wb", 32'(bus.wb_valid), 32'd0);
            check("abort_no_write", 32'(bus.mem_en), 32'd0);
        end
        do_op(LOAD, 8'h50, 8'h00, 8'h00, 3'd4, 0, g_ea, g_wb);
        check("abort_mem_unchanged", 32'(g_wb), 32'h33);

        // Randomized operations against the reference memory.
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            do_op(rop, 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)), g_ea, g_wb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store controller sitting directly upstream of the 256×8 data memory. Accepts one memory operation at a time from the execute stage over a valid/ready handshake, forms the effective address, drives the memory's `ea`/`result`/`mem_en` write port, samples its asynchronous `data` read port, and returns load results to writeback over a second valid/ready handshake. Supports load, store and atomic swap.

## Interface
- `AW`, 8, address width; memory depth is 2^AW.
- `DW`, 8, data width; data is signed two's complement.
- `TW`, 3, destination-register tag width.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock, reset is asynchronous and active-low.
- `in_valid` in 1: execute offers an operation.
- `in_ready` out 1: controller can accept; high only in IDLE.
- `in_op` in 2: 00 NOP, 01 LOAD, 10 STORE, 11 SWAP.
- `in_base` in AW: unsigned base address.
- `in_off` in AW: signed offset.
- `in_wdata` in DW: store/swap write data.
- `in_rd` in TW: destination tag, returned with the result.
- `ea` out AW: memory address, registered.
- `result` out DW: memory write data, registered.
- `mem_en` out 1: memory write enable, registered.
- `data` in DW: memory read data, combinational from `ea`.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback accepts.
- `wb_data` out DW: loaded or old value.
- `wb_rd` out TW: tag of the result.

## Operation
- Effective address: `in_base + sign_extend(in_off)`, truncated to AW bits (mod 256, wraps both ways).
- States: IDLE, RD, WR, WB.
- IDLE: `in_ready`=1. On `in_valid` the operation is captured into `ea`, `result` and the tag register:
  - LOAD goes to RD.
  - STORE goes to WR.
  - SWAP goes to RD.
  - NOP is consumed and the controller stays in IDLE. `ea` and `result` are unchanged.
- RD: `wb_data` <= `data` at the rising edge. LOAD then goes to WB; SWAP goes to WR.
- WR: `mem_en`=1 for exactly this one cycle. The memory commits on the falling edge inside WR. STORE then goes to IDLE; SWAP goes to WB.
- WB: `wb_valid`=1, and `wb_data`/`wb_rd` are held stable. Stay in WB until `wb_valid && wb_ready`, then go to IDLE.
- A STORE produces no writeback.
- SWAP returns the pre-write value. No other operation can interleave between its read and its write.
- `ea` and `result` hold their last values outside active states. `mem_en` is 0 in every state except WR.
- Reset values (asynchronous): state IDLE, `in_ready`=1, `mem_en`=0, `ea`=0, `result`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0.
- Reset asserted mid-operation aborts it. `mem_en` drops immediately. A write whose falling edge already occurred stands; no later write occurs. No writeback is produced.

## Timing
- Accept edge = T0, the rising edge where `in_valid && in_ready`.
- LOAD: RD during T0–T1; `wb_valid` high from T1. `in_ready` high again the edge after the WB handshake. Minimum occupancy is 2 cycles.
- STORE: `mem_en` high T0–T1, memory written at the falling edge between them. `in_ready` high from T1. Back-to-back stores are issued every 2 cycles.
- SWAP: RD T0–T1, WR T1–T2, `wb_valid` from T2.
- A LOAD issued right after a STORE to the same address returns the new value, because the write commits before the RD sample edge.
- `wb_ready` low holds WB indefinitely. No new operation is accepted meanwhile.

## Configuration
- `MEM_ACCESS_POSTINC_EN` defined:
  - Adds outputs `wb_base` (AW bits, = `ea + 1` mod 2^AW) and `wb_base_we` (1 bit).
  - `wb_base_we` pulses for one cycle on completion of every LOAD, STORE and SWAP: at the WB handshake, or in the WR cycle for STORE.
  - Both outputs reset to 0.
- Undefined: these ports and the logic behind them do not exist. All other behaviour is identical.

## Test plan
- STORE base 0x10, off 0x05, wdata 0x7F, then LOAD same address -> `mem_en` high for exactly one cycle with `ea`=0x15; load returns `wb_data`=0x7F.
- Address wrap: base 0x02 off 0xFD (−3) -> `ea`=0xFF. Base 0xFF off 0x01 -> `ea`=0x00.
- SWAP at 0x40 holding 0x33 with wdata 0xA5 -> `wb_data`=0x33; a following LOAD of 0x40 returns 0xA5 (−91).
- Hold `wb_ready`=0 for 5 cycles on a LOAD -> `wb_valid`, `wb_data` and `wb_rd` stable, `in_ready`=0 throughout; completes on the cycle `wb_ready` rises.
- Assert `rst` low during WR of a SWAP -> `mem_en`=0 and `wb_valid`=0 immediately, `in_ready`=1, no writeback after release.
- With `MEM_ACCESS_POSTINC_EN`: LOAD at 0xFF -> `wb_base`=0x00 with a one-cycle `wb_base_we` pulse.
